// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto a single memcontrol port.
// Define ARB_ROUND_ROBIN_EN to alternate between the ports on simultaneous requests instead of favouring LS.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic        ls_wr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic [31:0] ls_data,
  input  logic        flush,
  output logic        mc_valid,
  output logic [31:0] mc_addr,
  output logic [1:0]  mc_size,
  output logic        mc_op_tpe,
  output logic [31:0] mc_wdata,
  input  logic        mc_ready,
  input  logic [31:0] mc_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_LS = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0] state;
  logic       resp_ls;
  logic       if_flushed;
  logic       if_want;
  logic       grant_if;
  logic       grant_ls;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = IF, 1 = LS
  logic last_grant;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= 1'b0;
    end else if (grant_ls) begin
      last_grant <= 1'b1;
    end else if (grant_if) begin
      last_grant <= 1'b0;
    end
  end
`endif

  always_comb begin
    if_want  = if_req && !flush;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE && rdy_in) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_ls = ls_req && (!if_want || !last_grant);
      grant_if = if_want && (!ls_req || last_grant);
`else
      grant_ls = ls_req;
      grant_if = if_want && !ls_req;
`endif
    end
  end

  // Ready pulses are combinational so a stalled RESP cycle simply postpones them.
  assign if_ready = (state == RESP) && !resp_ls && !if_flushed && !flush && rdy_in;
  assign ls_ready = (state == RESP) && resp_ls && rdy_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      resp_ls    <= 1'b0;
      if_flushed <= 1'b0;
      mc_valid   <= 1'b0;
      mc_addr    <= '0;
      mc_size    <= '0;
      mc_op_tpe  <= 1'b0;
      mc_wdata   <= '0;
      if_data    <= '0;
      ls_data    <= '0;
    end else begin
      // A flush is remembered even while stalled so the fetch result is never delivered.
      if (state == BUSY_IF && flush) begin
        if_flushed <= 1'b1;
      end
      if (rdy_in) begin
        case (state)
          IDLE: begin
            if (grant_ls) begin
              state     <= BUSY_LS;
              resp_ls   <= 1'b1;
              mc_valid  <= 1'b1;
              mc_addr   <= ls_addr;
              mc_size   <= ls_size;
              mc_op_tpe <= ls_wr;
              mc_wdata  <= ls_wdata;
            end else if (grant_if) begin
              state      <= BUSY_IF;
              resp_ls    <= 1'b0;
              if_flushed <= 1'b0;
              mc_valid   <= 1'b1;
              mc_addr    <= if_addr;
              mc_size    <= 2'b11;
              mc_op_tpe  <= 1'b0;
              mc_wdata   <= '0;
            end
          end
          BUSY_IF, BUSY_LS: begin
            if (mc_ready) begin
              state    <= RESP;
              mc_valid <= 1'b0;
              if (state == BUSY_IF) begin
                if (!if_flushed && !flush) begin
                  if_data <= mc_data;
                end
              end else if (!mc_op_tpe) begin
                ls_data <= mc_data;
              end
            end
          end
          RESP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected values are hand-computed per scenario.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic        ls_wr;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_data;
  logic        flush;
  logic        mc_valid;
  logic [31:0] mc_addr;
  logic [1:0]  mc_size;
  logic        mc_op_tpe;
  logic [31:0] mc_wdata;
  logic        mc_ready;
  logic [31:0] mc_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_size(ls_size), .ls_wr(ls_wr),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_data(ls_data),
    .flush(flush),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_size(mc_size),
    .mc_op_tpe(mc_op_tpe), .mc_wdata(mc_wdata),
    .mc_ready(mc_ready), .mc_data(mc_data)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] data);
    mc_ready = 1'b1;
    mc_data  = data;
    step();
    mc_ready = 1'b0;
    mc_data  = '0;
  endtask

  initial begin
    logic expLs;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_addr = '0; ls_size = '0; ls_wr = 1'b0; ls_wdata = '0;
    mc_ready = 1'b0; mc_data = '0;
    step(); step();
    checkOutput("rst_mc_valid", {31'd0, mc_valid}, 32'd0);
    checkOutput("rst_mc_addr", mc_addr, 32'd0);
    checkOutput("rst_if_ready", {31'd0, if_ready}, 32'd0);
    checkOutput("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
    checkOutput("rst_if_data", if_data, 32'd0);
    checkOutput("rst_ls_data", ls_data, 32'd0);
    rst_in = 1'b0;
    step();

    // Basic fetch, memory answers three cycles after mc_valid
    if_req = 1'b1; if_addr = 32'h0000_1000;
    step();
    checkOutput("if_mc_valid", {31'd0, mc_valid}, 32'd1);
    checkOutput("if_mc_addr", mc_addr, 32'h0000_1000);
    checkOutput("if_mc_size", {30'd0, mc_size}, 32'd3);
    checkOutput("if_mc_op", {31'd0, mc_op_tpe}, 32'd0);
    step(); step();
    checkOutput("if_hold_valid", {31'd0, mc_valid}, 32'd1);
    checkOutput("if_hold_ready", {31'd0, if_ready}, 32'd0);
    step();
    applyStimulus(32'hDEAD_BEEF);
    checkOutput("if_ready_pulse", {31'd0, if_ready}, 32'd1);
    checkOutput("if_data", if_data, 32'hDEAD_BEEF);
    checkOutput("if_valid_drop", {31'd0, mc_valid}, 32'd0);
    if_req = 1'b0;
    step();
    checkOutput("if_ready_end", {31'd0, if_ready}, 32'd0);

    // Load then store: the store must leave ls_data untouched
    ls_req = 1'b1; ls_addr = 32'h0000_0040; ls_size = 2'd2; ls_wr = 1'b0;
    step();
    checkOutput("ld_mc_addr", mc_addr, 32'h0000_0040);
    checkOutput("ld_mc_size", {30'd0, mc_size}, 32'd2);
    applyStimulus(32'h1234_5678);
    checkOutput("ld_ready", {31'd0, ls_ready}, 32'd1);
    checkOutput("ld_data", ls_data, 32'h1234_5678);
    ls_req = 1'b0;
    step();
    ls_req = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'd0; ls_wr = 1'b1; ls_wdata = 32'h0000_00AB;
    step();
    checkOutput("st_mc_addr", mc_addr, 32'h0003_0000);
    checkOutput("st_mc_op", {31'd0, mc_op_tpe}, 32'd1);
    checkOutput("st_mc_wdata", mc_wdata, 32'h0000_00AB);
    checkOutput("st_mc_size", {30'd0, mc_size}, 32'd0);
    applyStimulus(32'hFFFF_FFFF);
    checkOutput("st_ready", {31'd0, ls_ready}, 32'd1);
    checkOutput("st_ls_data", ls_data, 32'h1234_5678);
    ls_req = 1'b0; ls_wr = 1'b0; ls_wdata = '0;
    step();

    // Ties: reset first so the round-robin history starts at IF
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_4000;
    ls_req = 1'b1; ls_addr = 32'h0000_8000; ls_size = 2'd2; ls_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expLs = (i != 1);
`else
      expLs = 1'b1;
`endif
      step();
      checkOutput($sformatf("tie%0d_addr", i), mc_addr, expLs ? 32'h0000_8000 : 32'h0000_4000);
      applyStimulus(32'hA000_0000 + i);
      checkOutput($sformatf("tie%0d_ls_ready", i), {31'd0, ls_ready}, {31'd0, expLs});
      checkOutput($sformatf("tie%0d_if_ready", i), {31'd0, if_ready}, {31'd0, !expLs});
      step();
    end
    ls_req = 1'b0;
    step();
    checkOutput("tie_if_addr", mc_addr, 32'h0000_4000);
    applyStimulus(32'hA000_0003);
    checkOutput("tie_if_ready", {31'd0, if_ready}, 32'd1);
    checkOutput("tie_if_data", if_data, 32'hA000_0003);
    if_req = 1'b0;
    step();

    // Flush during BUSY_IF discards the fetch result
    if_req = 1'b1; if_addr = 32'h0000_2000;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(32'h5555_5555);
    checkOutput("fl_if_ready", {31'd0, if_ready}, 32'd0);
    checkOutput("fl_mc_valid", {31'd0, mc_valid}, 32'd0);
    checkOutput("fl_if_data", if_data, 32'hA000_0003);
    if_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h0000_2004; flush = 1'b1;
    step();
    checkOutput("fl_idle_block", {31'd0, mc_valid}, 32'd0);
    flush = 1'b0;
    step();
    checkOutput("fl_next_valid", {31'd0, mc_valid}, 32'd1);
    checkOutput("fl_next_addr", mc_addr, 32'h0000_2004);
    applyStimulus(32'h6666_6666);
    checkOutput("fl_next_ready", {31'd0, if_ready}, 32'd1);
    checkOutput("fl_next_data", if_data, 32'h6666_6666);
    if_req = 1'b0;
    step();

    // rdy_in low stalls a completed load
    ls_req = 1'b1; ls_addr = 32'h0000_0050; ls_size = 2'd2; ls_wr = 1'b0;
    step();
    mc_ready = 1'b1; mc_data = 32'hCAFE_F00D; rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("stall%0d_valid", i), {31'd0, mc_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_ready", i), {31'd0, ls_ready}, 32'd0);
    end
    rdy_in = 1'b1;
    step();
    checkOutput("stall_ls_ready", {31'd0, ls_ready}, 32'd1);
    checkOutput("stall_ls_data", ls_data, 32'hCAFE_F00D);
    mc_ready = 1'b0; mc_data = '0; ls_req = 1'b0;
    step();
    checkOutput("stall_ready_end", {31'd0, ls_ready}, 32'd0);

    // Reset in the middle of a fetch
    if_req = 1'b1; if_addr = 32'h0000_3000;
    step();
    checkOutput("rm_valid", {31'd0, mc_valid}, 32'd1);
    mc_ready = 1'b1; mc_data = 32'h7777_7777; rst_in = 1'b1;
    #1;
    checkOutput("rm_async_valid", {31'd0, mc_valid}, 32'd0);
    checkOutput("rm_async_addr", mc_addr, 32'd0);
    checkOutput("rm_async_if_data", if_data, 32'd0);
    checkOutput("rm_async_ls_data", ls_data, 32'd0);
    step();
    checkOutput("rm_if_ready", {31'd0, if_ready}, 32'd0);
    rst_in = 1'b0; mc_ready = 1'b0; mc_data = '0;
    step();
    checkOutput("rm_regrant_valid", {31'd0, mc_valid}, 32'd1);
    checkOutput("rm_regrant_addr", mc_addr, 32'h0000_3000);
    applyStimulus(32'h8888_8888);
    checkOutput("rm_if_ready_pulse", {31'd0, if_ready}, 32'd1);
    checkOutput("rm_if_data", if_data, 32'h8888_8888);
    if_req = 1'b0;
    step();
    checkOutput("rm_if_ready_end", {31'd0, if_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
